// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared state encodings, wait counter width and master indices
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int   CNT_W  = 3;
  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational grant select between two masters
// SRAM_ARB_RR_EN: round-robin on ties; otherwise m0 always wins ties.
module sram_arb_pick (
  input  logic m0_req,
  input  logic m1_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);
  import sram_arbiter_pkg::*;

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_idx   = MST_M0;
    if (m0_req && m1_req) begin
      grant_idx = (last_grant == MST_M0) ? MST_M1 : MST_M0;
    end else if (m1_req) begin
      grant_idx = MST_M1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_idx   = (!m0_req && m1_req) ? MST_M1 : MST_M0;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master async SRAM arbiter, SETUP/STROBE/HOLD access cycle
// SRAM_ARB_RR_EN selects round-robin tie breaking (default: fixed priority m0).
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [16:0] m0_addr,
  input  logic [7:0]  m0_di,
  output logic [7:0]  m0_do,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [16:0] m1_addr,
  input  logic [7:0]  m1_di,
  output logic [7:0]  m1_do,
  output logic        m1_ack,
  output logic [16:0] SRAM_AD,
  inout  wire  [7:0]  SRAM_DQ,
  output logic        SRAM_WE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_CS2
);
  import sram_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [7:0]         di_q, di_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [16:0]        sram_ad_q, sram_ad_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               cs2_q, cs2_d;
  logic               dq_oe_q, dq_oe_d;
  logic [7:0]         m0_do_q, m0_do_d;
  logic [7:0]         m1_do_q, m1_do_d;
  logic               m0_ack_q, m0_ack_d;
  logic               m1_ack_q, m1_ack_d;
  logic               grant_valid, grant_idx;

  sram_arb_pick u_pick (
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    di_d      = di_q;
    win_d     = win_q;
    last_d    = last_q;
    sram_ad_d = sram_ad_q;
    m0_do_d   = m0_do_q;
    m1_do_d   = m1_do_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d   = ST_SETUP;
          win_d     = grant_idx;
          last_d    = grant_idx;
          rw_d      = (grant_idx == MST_M1) ? m1_rw   : m0_rw;
          di_d      = (grant_idx == MST_M1) ? m1_di   : m0_di;
          sram_ad_d = (grant_idx == MST_M1) ? m1_addr : m0_addr;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_HOLD;
          // Sample the bus while OE_n is still low on this closing edge.
          if (rw_q && win_q == MST_M0) m0_do_d = SRAM_DQ;
          if (rw_q && win_q == MST_M1) m1_do_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin strobes are registered images of the next state.
    cs2_d    = (state_d != ST_IDLE);
    dq_oe_d  = (state_d != ST_IDLE) && !rw_d;
    we_n_d   = !((state_d == ST_STROBE) && !rw_d);
    oe_n_d   = !((state_d == ST_STROBE) && rw_d);
    m0_ack_d = (state_d == ST_HOLD) && (win_d == MST_M0);
    m1_ack_d = (state_d == ST_HOLD) && (win_d == MST_M1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      di_q      <= '0;
      win_q     <= MST_M0;
      last_q    <= MST_M1;
      sram_ad_q <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      cs2_q     <= 1'b0;
      dq_oe_q   <= 1'b0;
      m0_do_q   <= '0;
      m1_do_q   <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      di_q      <= di_d;
      win_q     <= win_d;
      last_q    <= last_d;
      sram_ad_q <= sram_ad_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      cs2_q     <= cs2_d;
      dq_oe_q   <= dq_oe_d;
      m0_do_q   <= m0_do_d;
      m1_do_q   <= m1_do_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? di_q : 8'hzz;
  assign SRAM_AD   = sram_ad_q;
  assign SRAM_WE_n = we_n_q;
  assign SRAM_OE_n = oe_n_q;
  assign SRAM_CS2  = cs2_q;
  assign m0_do     = m0_do_q;
  assign m1_do     = m1_do_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
// Covers SRAM_ARB_RR_EN when the bench is built with that macro.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [16:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_di = '0, m1_di = '0;
  logic [7:0]  m0_do, m1_do;
  logic        m0_ack, m1_ack;
  logic [16:0] sram_ad;
  wire  [7:0]  sram_dq;
  logic        we_n, oe_n, cs2;
  logic [7:0]  model_data = 8'h00;

  // Asynchronous SRAM read model; pull-ups make an undriven bus read 0xFF.
  assign sram_dq = (!oe_n && cs2) ? model_data : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (sram_dq[g]);
  end

  sram_arbiter #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_di(m0_di), .m0_do(m0_do), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_di(m1_di), .m1_do(m1_do), .m1_ack(m1_ack),
    .SRAM_AD(sram_ad), .SRAM_DQ(sram_dq), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n), .SRAM_CS2(cs2)
  );

  logic        w_req = 1'b0;
  wire  [7:0]  w0_dq, w7_dq;
  logic [7:0]  w0_m0_do, w0_m1_do, w7_m0_do, w7_m1_do;
  logic        w0_m0_ack, w0_m1_ack, w7_m0_ack, w7_m1_ack;
  logic [16:0] w0_ad, w7_ad;
  logic        w0_we_n, w0_oe_n, w0_cs2, w7_we_n, w7_oe_n, w7_cs2;

  sram_arbiter #(.WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .m0_req(w_req), .m0_rw(1'b0), .m0_addr(17'h00055), .m0_di(8'h99), .m0_do(w0_m0_do), .m0_ack(w0_m0_ack),
    .m1_req(1'b0), .m1_rw(1'b0), .m1_addr(17'h0), .m1_di(8'h0), .m1_do(w0_m1_do), .m1_ack(w0_m1_ack),
    .SRAM_AD(w0_ad), .SRAM_DQ(w0_dq), .SRAM_WE_n(w0_we_n), .SRAM_OE_n(w0_oe_n), .SRAM_CS2(w0_cs2)
  );

  sram_arbiter #(.WAIT_STATES(7)) u_w7 (
    .clk(clk), .rst(rst),
    .m0_req(w_req), .m0_rw(1'b0), .m0_addr(17'h00055), .m0_di(8'h99), .m0_do(w7_m0_do), .m0_ack(w7_m0_ack),
    .m1_req(1'b0), .m1_rw(1'b0), .m1_addr(17'h0), .m1_di(8'h0), .m1_do(w7_m1_do), .m1_ack(w7_m1_ack),
    .SRAM_AD(w7_ad), .SRAM_DQ(w7_dq), .SRAM_WE_n(w7_we_n), .SRAM_OE_n(w7_oe_n), .SRAM_CS2(w7_cs2)
  );

  int checks = 0;
  int errors = 0;

  int         we_low, oe_low, a0, a1, a0_at, a1_at, ngr;
  int         gord [0:2];
  logic [7:0] dq_seen, m0_do_at_ack, m1_do_at_ack;
  int         w0_low, w7_low, w0_acks, w7_acks, w0_at, w7_at;

  // Runs ncyc cycles of the main DUT, sampling at the falling edge; cycle 1 follows the grant edge.
  task automatic watch(input int ncyc, input bit hold_req);
    we_low = 0; oe_low = 0; a0 = 0; a1 = 0; a0_at = 0; a1_at = 0; ngr = 0;
    dq_seen = 8'h00; m0_do_at_ack = 8'h00; m1_do_at_ack = 8'h00;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (!we_n) begin we_low++; dq_seen = sram_dq; end
      if (!oe_n) oe_low++;
      if (m0_ack) begin
        a0++; if (a0_at == 0) a0_at = i;
        m0_do_at_ack = m0_do;
        if (ngr < 3) gord[ngr] = 0;
        ngr++;
        if (!hold_req) m0_req = 1'b0;
      end
      if (m1_ack) begin
        a1++; if (a1_at == 0) a1_at = i;
        m1_do_at_ack = m1_do;
        if (ngr < 3) gord[ngr] = 1;
        ngr++;
        if (!hold_req) m1_req = 1'b0;
      end
    end
  endtask

  task automatic watch_w(input int ncyc);
    w0_low = 0; w7_low = 0; w0_acks = 0; w7_acks = 0; w0_at = 0; w7_at = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1) w_req = 1'b0;
      if (!w0_we_n) w0_low++;
      if (!w7_we_n) w7_low++;
      if (w0_m0_ack) begin w0_acks++; if (w0_at == 0) w0_at = i; end
      if (w7_m0_ack) begin w7_acks++; if (w7_at == 0) w7_at = i; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (we_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL reset_strobes: we_n=%b oe_n=%b expected 1 1", we_n, oe_n); end
    checks++; if (cs2 !== 1'b0) begin errors++; $display("FAIL reset_cs2: got %b expected 0", cs2); end
    checks++; if (sram_ad !== 17'h0) begin errors++; $display("FAIL reset_ad: got %h expected 00000", sram_ad); end
    checks++; if (sram_dq !== 8'hFF) begin errors++; $display("FAIL reset_dq_hiz: got %h expected ff (released)", sram_dq); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_do !== 8'h00 || m1_do !== 8'h00) begin
      errors++; $display("FAIL reset_masters: ack=%b%b do=%h/%h expected 00 00/00", m0_ack, m1_ack, m0_do, m1_do);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    m0_rw = 1'b0; m0_addr = 17'h1A5A5; m0_di = 8'h3C; m0_req = 1'b1;
    watch(8, 1'b0);
    checks++; if (sram_ad !== 17'h1A5A5) begin errors++; $display("FAIL write_ad: got %h expected 1a5a5", sram_ad); end
    checks++; if (we_low != 2) begin errors++; $display("FAIL write_we_len: got %0d expected 2", we_low); end
    checks++; if (dq_seen !== 8'h3C) begin errors++; $display("FAIL write_dq: got %h expected 3c", dq_seen); end
    checks++; if (a0 != 1 || a0_at != 4) begin errors++; $display("FAIL write_ack: count %0d at %0d expected 1 at 4", a0, a0_at); end
    checks++; if (a1 != 0 || oe_low != 0) begin errors++; $display("FAIL write_side: m1 acks %0d oe_low %0d expected 0 0", a1, oe_low); end
    checks++; if (sram_dq !== 8'hFF || cs2 !== 1'b0) begin errors++; $display("FAIL write_release: dq=%h cs2=%b expected ff 0", sram_dq, cs2); end
  endtask

  task automatic test_read();
    model_data = 8'h7E;
    m1_rw = 1'b1; m1_addr = 17'h00100; m1_di = 8'h00; m1_req = 1'b1;
    watch(8, 1'b0);
    checks++; if (sram_ad !== 17'h00100) begin errors++; $display("FAIL read_ad: got %h expected 00100", sram_ad); end
    checks++; if (oe_low != 2 || we_low != 0) begin errors++; $display("FAIL read_strobes: oe_low %0d we_low %0d expected 2 0", oe_low, we_low); end
    checks++; if (a1 != 1 || a1_at != 4) begin errors++; $display("FAIL read_ack: count %0d at %0d expected 1 at 4", a1, a1_at); end
    checks++; if (m1_do_at_ack !== 8'h7E) begin errors++; $display("FAIL read_data: got %h expected 7e", m1_do_at_ack); end
    checks++; if (m0_do !== 8'h00 || a0 != 0) begin errors++; $display("FAIL read_loser: m0_do %h acks %0d expected 00 0", m0_do, a0); end
    checks++; if (m1_do !== 8'h7E) begin errors++; $display("FAIL read_hold_do: got %h expected 7e", m1_do); end
  endtask

  task automatic test_tie();
    m0_rw = 1'b0; m0_addr = 17'h00010; m0_di = 8'h11;
    m1_rw = 1'b0; m1_addr = 17'h00020; m1_di = 8'h22;
    m0_req = 1'b1; m1_req = 1'b1;
    watch(12, 1'b0);
    checks++; if (a0 != 1 || a0_at != 4) begin errors++; $display("FAIL tie_first: m0 count %0d at %0d expected 1 at 4", a0, a0_at); end
    checks++; if (a1 != 1 || a1_at != 9) begin errors++; $display("FAIL tie_second: m1 count %0d at %0d expected 1 at 9", a1, a1_at); end
    checks++; if (sram_ad !== 17'h00020) begin errors++; $display("FAIL tie_ad: got %h expected 00020", sram_ad); end
  endtask

  task automatic test_back_to_back();
    int exp_g [0:2];
`ifdef SRAM_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0;
`endif
    m0_req = 1'b1; m1_req = 1'b1;
    watch(14, 1'b1);
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (ngr != 3) begin errors++; $display("FAIL b2b_count: got %0d grants expected 3", ngr); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ngr > i && gord[i] != exp_g[i]) begin
        errors++; $display("FAIL b2b_order[%0d]: got m%0d expected m%0d", i, gord[i], exp_g[i]);
      end
    end
    watch(3, 1'b0);
    checks++; if (ngr != 0 || cs2 !== 1'b0) begin errors++; $display("FAIL b2b_drain: grants %0d cs2 %b expected 0 0", ngr, cs2); end
  endtask

  task automatic test_reset_mid();
    m0_rw = 1'b0; m0_addr = 17'h0ABCD; m0_di = 8'h5A; m0_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (we_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_strobe: we_n %b expected 0", we_n); end
    #1 rst = 1'b1;
    #1;
    checks++; if (we_n !== 1'b1 || sram_dq !== 8'hFF || cs2 !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: we_n %b dq %h cs2 %b expected 1 ff 0", we_n, sram_dq, cs2);
    end
    watch(3, 1'b0);
    checks++; if (a0 != 0 || we_low != 0) begin errors++; $display("FAIL rstmid_no_ack: acks %0d we_low %0d expected 0 0", a0, we_low); end
    rst = 1'b0;
    watch(8, 1'b0);
    checks++; if (a0 != 1 || a0_at != 4) begin errors++; $display("FAIL rstmid_retry_ack: count %0d at %0d expected 1 at 4", a0, a0_at); end
    checks++; if (we_low != 2 || dq_seen !== 8'h5A) begin errors++; $display("FAIL rstmid_retry_write: we_low %0d dq %h expected 2 5a", we_low, dq_seen); end
  endtask

  task automatic test_wait_states();
    w_req = 1'b1;
    watch_w(14);
    checks++; if (w0_low != 1) begin errors++; $display("FAIL ws0_strobe: got %0d expected 1", w0_low); end
    checks++; if (w7_low != 8) begin errors++; $display("FAIL ws7_strobe: got %0d expected 8", w7_low); end
    checks++; if (w0_acks != 1 || w0_at != 3) begin errors++; $display("FAIL ws0_ack: count %0d at %0d expected 1 at 3", w0_acks, w0_at); end
    checks++; if (w7_acks != 1 || w7_at != 10) begin errors++; $display("FAIL ws7_ack: count %0d at %0d expected 1 at 10", w7_acks, w7_at); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_wait_states();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
